// File: rtl/msrh_alu_rs_multi_if.sv
// Bus between the ALU reservation station, the dispatch stage and the ALU pipes.
// The master side drives dispatch, wakeup, replay, done and flush; the slave
// side (the reservation station) returns issue, free-count and ready status.
interface msrh_alu_rs_multi_if #(
  parameter int ENTRY_SIZE     = 8,
  parameter int IN_PORT_SIZE   = 2,
  parameter int ISS_PORT_SIZE  = 2,
  parameter int WAKE_PORT_SIZE = 4,
  parameter int TAG_W          = 7,
  parameter int PAYLOAD_W      = 64
);
  localparam int FC_W = $clog2(ENTRY_SIZE + 1);

  logic [IN_PORT_SIZE-1:0]             i_disp_valid;
  logic [IN_PORT_SIZE*2*TAG_W-1:0]     i_disp_rs_tag;
  logic [IN_PORT_SIZE*2-1:0]           i_disp_rs_rdy;
  logic [IN_PORT_SIZE*PAYLOAD_W-1:0]   i_disp_payload;
  logic                                o_disp_ready;
  logic [WAKE_PORT_SIZE-1:0]           i_wake_valid;
  logic [WAKE_PORT_SIZE*TAG_W-1:0]     i_wake_tag;
  logic [ISS_PORT_SIZE-1:0]            o_iss_valid;
  logic [ISS_PORT_SIZE*PAYLOAD_W-1:0]  o_iss_payload;
  logic [ISS_PORT_SIZE*ENTRY_SIZE-1:0] o_iss_index_oh;
  logic [ISS_PORT_SIZE-1:0]            i_ex0_conflict;
  logic                                i_done_valid;
  logic [ENTRY_SIZE-1:0]               i_done_index_oh;
  logic                                i_flush;
  logic [FC_W-1:0]                     o_free_count;

  modport master (
    output i_disp_valid, i_disp_rs_tag, i_disp_rs_rdy, i_disp_payload,
    output i_wake_valid, i_wake_tag, i_ex0_conflict, i_done_valid,
    output i_done_index_oh, i_flush,
    input  o_disp_ready, o_iss_valid, o_iss_payload, o_iss_index_oh, o_free_count
  );

  modport slave (
    input  i_disp_valid, i_disp_rs_tag, i_disp_rs_rdy, i_disp_payload,
    input  i_wake_valid, i_wake_tag, i_ex0_conflict, i_done_valid,
    input  i_done_index_oh, i_flush,
    output o_disp_ready, o_iss_valid, o_iss_payload, o_iss_index_oh, o_free_count
  );
endinterface

// File: rtl/msrh_alu_rs_multi.sv
// ALU reservation station: multi-port dispatch into lowest free entries, tag
// wakeup of pending operands, oldest-first multi-port issue via an age matrix,
// replay on EX0 conflict, release on pipe done, and global flush.
// older_q[i][j] = 1 means entry j is older than entry i.
module msrh_alu_rs_multi #(
  parameter int ENTRY_SIZE     = 8,
  parameter int IN_PORT_SIZE   = 2,
  parameter int ISS_PORT_SIZE  = 2,
  parameter int WAKE_PORT_SIZE = 4,
  parameter int TAG_W          = 7,
  parameter int PAYLOAD_W      = 64
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  msrh_alu_rs_multi_if.slave bus
);
  localparam int FC_W = $clog2(ENTRY_SIZE + 1);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_WAIT   = 2'd1,
    S_READY  = 2'd2,
    S_ISSUED = 2'd3
  } ent_state_e;

  ent_state_e            state_q    [ENTRY_SIZE];
  ent_state_e            state_d    [ENTRY_SIZE];
  logic [ENTRY_SIZE-1:0] older_q    [ENTRY_SIZE];
  logic [ENTRY_SIZE-1:0] older_d    [ENTRY_SIZE];
  logic [ENTRY_SIZE-1:0] last_iss_q [ISS_PORT_SIZE];
  logic [ENTRY_SIZE-1:0] rdy1_q, rdy1_d, rdy2_q, rdy2_d;
  logic [TAG_W-1:0]      tag1_q [ENTRY_SIZE];
  logic [TAG_W-1:0]      tag1_d [ENTRY_SIZE];
  logic [TAG_W-1:0]      tag2_q [ENTRY_SIZE];
  logic [TAG_W-1:0]      tag2_d [ENTRY_SIZE];
  logic [PAYLOAD_W-1:0]  payload_q [ENTRY_SIZE];
  logic [PAYLOAD_W-1:0]  payload_d [ENTRY_SIZE];

  logic [ENTRY_SIZE-1:0] free_mask, ready_mask, iss_mask;
  logic [ENTRY_SIZE-1:0] sel      [ISS_PORT_SIZE];
  logic [ENTRY_SIZE-1:0] alloc_oh [IN_PORT_SIZE];
  logic [FC_W-1:0]       free_cnt;
  logic                  alloc_en;

  function automatic logic wake_hit(input logic [TAG_W-1:0]                tag,
                                    input logic [WAKE_PORT_SIZE-1:0]       vld,
                                    input logic [WAKE_PORT_SIZE*TAG_W-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int w = 0; w < WAKE_PORT_SIZE; w++) begin
      if (vld[w] && (tags[w*TAG_W +: TAG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Classify entries and count free slots from registered state only
  always_comb begin
    free_mask  = '0;
    ready_mask = '0;
    free_cnt   = '0;
    for (int i = 0; i < ENTRY_SIZE; i++) begin
      free_mask[i]  = (state_q[i] == S_FREE);
      ready_mask[i] = (state_q[i] == S_READY);
      free_cnt      = free_cnt + FC_W'(free_mask[i]);
    end
  end

  assign bus.o_free_count = free_cnt;
  assign bus.o_disp_ready = (free_cnt >= FC_W'(IN_PORT_SIZE));
  assign alloc_en         = bus.o_disp_ready && !bus.i_flush;

  // Oldest-first select: each port takes the oldest candidate left by lower ports
  always_comb begin
    logic [ENTRY_SIZE-1:0] cand;
    logic                  found;
    cand     = ready_mask;
    iss_mask = '0;
    for (int p = 0; p < ISS_PORT_SIZE; p++) begin
      sel[p] = '0;
      found  = 1'b0;
      for (int i = 0; i < ENTRY_SIZE; i++) begin
        if (!found && cand[i] && ((older_q[i] & cand) == '0)) begin
          sel[p][i] = 1'b1;
          found     = 1'b1;
        end
      end
      cand     = cand & ~sel[p];
      iss_mask = iss_mask | sel[p];
    end
  end

  // Drive issue ports from the selection; idle ports stay all-zero
  always_comb begin
    bus.o_iss_valid    = '0;
    bus.o_iss_payload  = '0;
    bus.o_iss_index_oh = '0;
    for (int p = 0; p < ISS_PORT_SIZE; p++) begin
      bus.o_iss_valid[p] = |sel[p];
      bus.o_iss_index_oh[p*ENTRY_SIZE +: ENTRY_SIZE] = sel[p];
      for (int i = 0; i < ENTRY_SIZE; i++) begin
        if (sel[p][i]) bus.o_iss_payload[p*PAYLOAD_W +: PAYLOAD_W] = payload_q[i];
      end
    end
  end

  // Give valid dispatch ports, in port order, the lowest-index free entries
  always_comb begin
    logic [ENTRY_SIZE-1:0] avail;
    logic                  found;
    avail = free_mask;
    for (int p = 0; p < IN_PORT_SIZE; p++) begin
      alloc_oh[p] = '0;
      found       = 1'b0;
      if (alloc_en && bus.i_disp_valid[p]) begin
        for (int i = 0; i < ENTRY_SIZE; i++) begin
          if (!found && avail[i]) begin
            alloc_oh[p][i] = 1'b1;
            found          = 1'b1;
          end
        end
      end
      avail = avail & ~alloc_oh[p];
    end
  end

  // Next entry state: wakeup, issue, replay, done, alloc, then flush overrides all
  always_comb begin
    logic [ENTRY_SIZE-1:0] prior;
    for (int i = 0; i < ENTRY_SIZE; i++) begin
      state_d[i]   = state_q[i];
      older_d[i]   = older_q[i];
      tag1_d[i]    = tag1_q[i];
      tag2_d[i]    = tag2_q[i];
      payload_d[i] = payload_q[i];
      rdy1_d[i]    = rdy1_q[i];
      rdy2_d[i]    = rdy2_q[i];
      if (state_q[i] == S_WAIT) begin
        rdy1_d[i] = rdy1_q[i] | wake_hit(tag1_q[i], bus.i_wake_valid, bus.i_wake_tag);
        rdy2_d[i] = rdy2_q[i] | wake_hit(tag2_q[i], bus.i_wake_valid, bus.i_wake_tag);
        if (rdy1_d[i] && rdy2_d[i]) state_d[i] = S_READY;
      end
      if (iss_mask[i]) state_d[i] = S_ISSUED;
    end
    for (int p = 0; p < ISS_PORT_SIZE; p++) begin
      for (int i = 0; i < ENTRY_SIZE; i++) begin
        if (bus.i_ex0_conflict[p] && last_iss_q[p][i] && (state_q[i] == S_ISSUED))
          state_d[i] = S_READY;
      end
    end
    for (int i = 0; i < ENTRY_SIZE; i++) begin
      if (bus.i_done_valid && bus.i_done_index_oh[i] && (state_q[i] == S_ISSUED)) begin
        state_d[i] = S_FREE;
        older_d[i] = '0;
      end
    end
    // New entries are younger than every live entry and than lower-port allocations
    prior = ~free_mask;
    for (int p = 0; p < IN_PORT_SIZE; p++) begin
      for (int k = 0; k < ENTRY_SIZE; k++) older_d[k] = older_d[k] & ~alloc_oh[p];
      for (int i = 0; i < ENTRY_SIZE; i++) begin
        if (alloc_oh[p][i]) begin
          older_d[i]   = prior;
          tag1_d[i]    = bus.i_disp_rs_tag[p*2*TAG_W +: TAG_W];
          tag2_d[i]    = bus.i_disp_rs_tag[p*2*TAG_W+TAG_W +: TAG_W];
          payload_d[i] = bus.i_disp_payload[p*PAYLOAD_W +: PAYLOAD_W];
          rdy1_d[i]    = bus.i_disp_rs_rdy[2*p] |
                         wake_hit(tag1_d[i], bus.i_wake_valid, bus.i_wake_tag);
          rdy2_d[i]    = bus.i_disp_rs_rdy[2*p+1] |
                         wake_hit(tag2_d[i], bus.i_wake_valid, bus.i_wake_tag);
          state_d[i]   = (rdy1_d[i] && rdy2_d[i]) ? S_READY : S_WAIT;
        end
      end
      prior = prior | alloc_oh[p];
    end
    if (bus.i_flush) begin
      for (int i = 0; i < ENTRY_SIZE; i++) begin
        state_d[i] = S_FREE;
        older_d[i] = '0;
      end
    end
  end

  // Control state: entry FSMs, age matrix and last-issued record per port
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < ENTRY_SIZE; i++) begin
        state_q[i] <= S_FREE;
        older_q[i] <= '0;
      end
      for (int p = 0; p < ISS_PORT_SIZE; p++) last_iss_q[p] <= '0;
    end else begin
      for (int i = 0; i < ENTRY_SIZE; i++) begin
        state_q[i] <= state_d[i];
        older_q[i] <= older_d[i];
      end
      for (int p = 0; p < ISS_PORT_SIZE; p++) last_iss_q[p] <= sel[p];
    end
  end

  // Operand tags, readiness and payload; only meaningful while the entry is live
  always_ff @(posedge i_clk) begin
    rdy1_q <= rdy1_d;
    rdy2_q <= rdy2_d;
    for (int i = 0; i < ENTRY_SIZE; i++) begin
      tag1_q[i]    <= tag1_d[i];
      tag2_q[i]    <= tag2_d[i];
      payload_q[i] <= payload_d[i];
    end
  end
endmodule

// File: tb/tb_msrh_alu_rs_multi.sv
// Directed bench for the ALU reservation station (default parameters).
module tb_msrh_alu_rs_multi;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk, n_pass, n_fail;

  always #5 clk = ~clk;

  msrh_alu_rs_multi_if bus ();

  msrh_alu_rs_multi dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", name, obs, exp);
    end
  endtask

  task automatic idle();
    bus.i_disp_valid    = '0;
    bus.i_disp_rs_tag   = '0;
    bus.i_disp_rs_rdy   = '0;
    bus.i_disp_payload  = '0;
    bus.i_wake_valid    = '0;
    bus.i_wake_tag      = '0;
    bus.i_ex0_conflict  = '0;
    bus.i_done_valid    = 1'b0;
    bus.i_done_index_oh = '0;
    bus.i_flush         = 1'b0;
  endtask

  task automatic disp(input int p, input logic [6:0] t1, input logic [6:0] t2,
                      input logic [1:0] rdy, input logic [63:0] pl);
    bus.i_disp_valid[p]           = 1'b1;
    bus.i_disp_rs_tag[p*14 +: 14] = {t2, t1};
    bus.i_disp_rs_rdy[p*2 +: 2]   = rdy;
    bus.i_disp_payload[p*64 +: 64] = pl;
  endtask

  task automatic wake(input int w, input logic [6:0] tag);
    bus.i_wake_valid[w]      = 1'b1;
    bus.i_wake_tag[w*7 +: 7] = tag;
  endtask

  task automatic done(input logic [7:0] oh);
    bus.i_done_valid    = 1'b1;
    bus.i_done_index_oh = oh;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; n_fail = 0;
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_free_count", bus.o_free_count, 8);
    chk("rst_disp_ready", bus.o_disp_ready, 1);
    chk("rst_iss_valid", bus.o_iss_valid, 0);
    chk("rst_iss_payload", bus.o_iss_payload, 0);
    chk("rst_iss_index", bus.o_iss_index_oh, 0);
    rst_n = 1'b1;

    // Both operands ready: issue the very next cycle from entry 0
    disp(0, 7'd0, 7'd0, 2'b11, 64'hA5);
    tick(); idle();
    chk("t1_iss_valid", bus.o_iss_valid, 2'b01);
    chk("t1_payload", bus.o_iss_payload[63:0], 64'hA5);
    chk("t1_index", bus.o_iss_index_oh, 16'h0001);
    chk("t1_free", bus.o_free_count, 7);
    tick();
    chk("t1_no_reissue", bus.o_iss_valid, 2'b00);
    done(8'h01);
    tick(); idle();
    chk("t1_freed", bus.o_free_count, 8);

    // rs1 tag 5 pending; wake two cycles later, issue one cycle after wake
    disp(0, 7'd5, 7'd0, 2'b10, 64'h22);
    tick(); idle();
    chk("t2_wait0", bus.o_iss_valid, 2'b00);
    chk("t2_free", bus.o_free_count, 7);
    tick();
    chk("t2_wait1", bus.o_iss_valid, 2'b00);
    wake(1, 7'd5);
    tick(); idle();
    chk("t2_iss_valid", bus.o_iss_valid, 2'b01);
    chk("t2_index", bus.o_iss_index_oh, 16'h0001);
    chk("t2_payload", bus.o_iss_payload[63:0], 64'h22);
    tick();
    done(8'h01);
    tick(); idle();
    chk("t2_freed", bus.o_free_count, 8);

    // Port 1 alone with same-cycle wake of its pending operand
    disp(1, 7'd9, 7'd10, 2'b10, 64'h33);
    wake(3, 7'd9);
    tick(); idle();
    chk("tw_iss_valid", bus.o_iss_valid, 2'b01);
    chk("tw_index", bus.o_iss_index_oh, 16'h0001);
    chk("tw_payload", bus.o_iss_payload[63:0], 64'h33);
    tick();
    done(8'h01);
    tick(); idle();
    chk("tw_freed", bus.o_free_count, 8);

    // Fill all 8 entries over 4 cycles, issues go oldest-first in pairs
    disp(0, 7'd0, 7'd0, 2'b11, 64'h40); disp(1, 7'd0, 7'd0, 2'b11, 64'h41);
    tick(); idle();
    chk("t3_index01", bus.o_iss_index_oh, 16'h0201);
    chk("t3_valid01", bus.o_iss_valid, 2'b11);
    chk("t3_free6", bus.o_free_count, 6);
    disp(0, 7'd0, 7'd0, 2'b11, 64'h42); disp(1, 7'd0, 7'd0, 2'b11, 64'h43);
    tick(); idle();
    chk("t3_index23", bus.o_iss_index_oh, 16'h0804);
    chk("t3_free4", bus.o_free_count, 4);
    disp(0, 7'd0, 7'd0, 2'b11, 64'h44); disp(1, 7'd0, 7'd0, 2'b11, 64'h45);
    tick(); idle();
    chk("t3_index45", bus.o_iss_index_oh, 16'h2010);
    chk("t3_free2", bus.o_free_count, 2);
    chk("t3_ready_at2", bus.o_disp_ready, 1);
    disp(0, 7'd0, 7'd0, 2'b11, 64'h46); disp(1, 7'd0, 7'd0, 2'b11, 64'h47);
    tick(); idle();
    chk("t3_index67", bus.o_iss_index_oh, 16'h8040);
    chk("t3_payload67", bus.o_iss_payload, {64'h47, 64'h46});
    chk("t3_free0", bus.o_free_count, 0);
    chk("t3_not_ready_at0", bus.o_disp_ready, 0);
    tick();
    chk("t3_all_issued", bus.o_iss_valid, 2'b00);
    // Replay entry 6 (port 0 last cycle) and retire entry 0
    bus.i_ex0_conflict[0] = 1'b1;
    done(8'h01);
    tick(); idle();
    chk("t4_replay_index", bus.o_iss_index_oh, 16'h0040);
    chk("t4_replay_payload", bus.o_iss_payload[63:0], 64'h46);
    chk("t3_free1", bus.o_free_count, 1);
    chk("t3_not_ready_at1", bus.o_disp_ready, 0);
    done(8'h02);
    tick(); idle();
    chk("t4_free2", bus.o_free_count, 2);
    chk("t4_idle", bus.o_iss_valid, 2'b00);
    // Replay entry 6 again while two younger ready ops arrive in entries 0,1
    bus.i_ex0_conflict[0] = 1'b1;
    disp(0, 7'd0, 7'd0, 2'b11, 64'h50); disp(1, 7'd0, 7'd0, 2'b11, 64'h51);
    tick(); idle();
    chk("t4_age_valid", bus.o_iss_valid, 2'b11);
    chk("t4_age_index", bus.o_iss_index_oh, 16'h0140);
    chk("t4_age_payload", bus.o_iss_payload, {64'h50, 64'h46});
    chk("t4_free0", bus.o_free_count, 0);
    tick();
    chk("t4_young_index", bus.o_iss_index_oh, 16'h0002);
    chk("t4_young_payload", bus.o_iss_payload[63:0], 64'h51);
    // Entry 0 is ISSUED and frees; entry 1 is still READY so its done is ignored
    done(8'h03);
    tick(); idle();
    chk("t5_done_nonissued", bus.o_free_count, 1);
    done(8'h02);
    tick(); idle();
    chk("t5_free2", bus.o_free_count, 2);
    // Done of entries 2,3 alongside a two-port allocation
    done(8'h0C);
    disp(0, 7'd20, 7'd0, 2'b10, 64'h60); disp(1, 7'd21, 7'd0, 2'b10, 64'h61);
    tick(); idle();
    chk("t5_free_after", bus.o_free_count, 2);
    chk("t5_waiting", bus.o_iss_valid, 2'b00);
    wake(0, 7'd21);
    tick(); idle();
    chk("t5_alloc_entry1", bus.o_iss_index_oh, 16'h0002);
    chk("t5_alloc_payload", bus.o_iss_payload[63:0], 64'h61);

    // Flush wins over same-cycle dispatch, done and wakeup
    bus.i_flush = 1'b1;
    disp(0, 7'd0, 7'd0, 2'b11, 64'h70);
    done(8'h10);
    wake(2, 7'd20);
    tick(); idle();
    chk("t6_free8", bus.o_free_count, 8);
    chk("t6_no_issue", bus.o_iss_valid, 2'b00);
    chk("t6_ready", bus.o_disp_ready, 1);
    tick();
    chk("t6_still_empty", bus.o_iss_valid, 2'b00);

    // Asynchronous reset in the middle of a cycle with a live entry
    disp(0, 7'd0, 7'd0, 2'b11, 64'h80);
    tick(); idle();
    chk("t7_pre_iss", bus.o_iss_valid, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_async_free", bus.o_free_count, 8);
    chk("t7_async_iss", bus.o_iss_valid, 2'b00);
    chk("t7_async_index", bus.o_iss_index_oh, 16'h0000);
    #2 rst_n = 1'b1;
    tick();
    chk("t7_post_free", bus.o_free_count, 8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
